// File: rtl/spgd_meas_sched.sv
// ---------------------------------------------------------------------------
// spgd_meas_sched
// Measurement sequencer for one SPGD iteration. On START it applies the +delta
// perturbation, waits for the DAC to settle, captures one averaged ADC result,
// repeats at -delta, then presents J+, J- and dJ = J+ - J- over valid/ready.
//
// Optional feature macro: ADC_TIMEOUT_EN (wait-state timeout with sticky ERR).
//
// Ports:
//   ADC_CLK        sole clock
//   RST            asynchronous, active-high reset
//   START          single-cycle iteration request (honoured only in IDLE)
//   BUSY           high in every state except IDLE
//   PERTURB_SIGN   0 = +delta, 1 = -delta
//   PERTURB_APPLY  DAC update request, held until DAC_ACK
//   DAC_ACK        DAC took the new perturbation
//   ADC_EN         ADC front-end enable (capture states)
//   ADC_DONE       averager status, not used for sequencing
//   ADC_WRITE      front-end result strobe
//   ADC_DATA       front-end result (16.48 fixed point)
//   J_PLUS/J_MINUS latched +delta / -delta results
//   DELTA_J        J_PLUS - J_MINUS, two's complement, modulo 2^FP_WIDTH
//   RES_VALID      result available (HOLD state)
//   RES_READY      consumer accepts the result
//   ERR            sticky timeout flag (constant 0 without ADC_TIMEOUT_EN)
//   DBG_STATE      current FSM state encoding
//
// Result handshake: the result transfers on a rising edge where RES_VALID and
// RES_READY are both high; RES_VALID does not drop before that edge and the
// J/DELTA_J outputs do not change while RES_VALID is high.
// ---------------------------------------------------------------------------
module spgd_meas_sched #(
  parameter int FP_WIDTH       = 64,
  parameter int CNT_WIDTH      = 16,
  parameter int SETTLE_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                ADC_CLK,
  input  logic                RST,
  input  logic                START,
  output logic                BUSY,
  output logic                PERTURB_SIGN,
  output logic                PERTURB_APPLY,
  input  logic                DAC_ACK,
  output logic                ADC_EN,
  input  logic                ADC_DONE,
  input  logic                ADC_WRITE,
  input  logic [FP_WIDTH-1:0] ADC_DATA,
  output logic [FP_WIDTH-1:0] J_PLUS,
  output logic [FP_WIDTH-1:0] J_MINUS,
  output logic [FP_WIDTH-1:0] DELTA_J,
  output logic                RES_VALID,
  input  logic                RES_READY,
  output logic                ERR,
  output logic [3:0]          DBG_STATE
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    APPLY_P  = 4'd1,
    SETTLE_P = 4'd2,
    CAPT_P   = 4'd3,
    APPLY_M  = 4'd4,
    SETTLE_M = 4'd5,
    CAPT_M   = 4'd6,
    CALC     = 4'd7,
    HOLD     = 4'd8
  } state_e;

  // A zero settle time still costs one cycle in the SETTLE state.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_EFF - 1);

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  settle_q;
  logic [FP_WIDTH-1:0]   jp_q;
  logic [FP_WIDTH-1:0]   jm_q;
  logic [FP_WIDTH-1:0]   dj_q;

  // Averager status is informational only.
  logic unused_done;
  assign unused_done = ADC_DONE;

`ifdef ADC_TIMEOUT_EN
  localparam int TMO_EFF = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TMO_EFF - 1);

  logic [CNT_WIDTH-1:0] tmo_q;
  logic                 err_q;
  logic                 wait_st;
  logic                 wait_exit;

  assign wait_st   = (state_q == APPLY_P) || (state_q == APPLY_M) ||
                     (state_q == CAPT_P)  || (state_q == CAPT_M);
  // The event that legitimately ends the current wait state.
  assign wait_exit = ((state_q == APPLY_P) || (state_q == APPLY_M)) ? DAC_ACK : ADC_WRITE;
  assign ERR       = err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign ERR = 1'b0;
`endif

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      settle_q <= '0;
      jp_q     <= '0;
      jm_q     <= '0;
      dj_q     <= '0;
`ifdef ADC_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE:     if (START) state_q <= APPLY_P;
        APPLY_P:  if (DAC_ACK) begin
                    state_q  <= SETTLE_P;
                    settle_q <= SETTLE_LOAD;
                  end
        SETTLE_P: if (settle_q == '0) state_q <= CAPT_P;
                  else settle_q <= settle_q - 1'b1;
        CAPT_P:   if (ADC_WRITE) begin
                    jp_q    <= ADC_DATA;
                    state_q <= APPLY_M;
                  end
        APPLY_M:  if (DAC_ACK) begin
                    state_q  <= SETTLE_M;
                    settle_q <= SETTLE_LOAD;
                  end
        SETTLE_M: if (settle_q == '0) state_q <= CAPT_M;
                  else settle_q <= settle_q - 1'b1;
        CAPT_M:   if (ADC_WRITE) begin
                    jm_q    <= ADC_DATA;
                    state_q <= CALC;
                  end
        CALC: begin
          dj_q    <= jp_q - jm_q;
          state_q <= HOLD;
        end
        HOLD:     if (RES_READY) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase

`ifdef ADC_TIMEOUT_EN
      if ((state_q == IDLE) && START) err_q <= 1'b0;
      // Counter runs only while stuck in a wait state; any state change
      // clears it. Placed after the case so the abort wins over it.
      if (wait_st && !wait_exit) begin
        if (tmo_q == TMO_LAST) begin
          state_q <= IDLE;
          err_q   <= 1'b1;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
`endif
    end
  end

  // Decoded from the registered state, so RST drops them asynchronously.
  assign BUSY          = (state_q != IDLE);
  assign PERTURB_APPLY = (state_q == APPLY_P) || (state_q == APPLY_M);
  assign ADC_EN        = (state_q == CAPT_P) || (state_q == CAPT_M);
  // Sign stays at -delta from APPLY_M until the return to IDLE.
  assign PERTURB_SIGN  = (state_q == APPLY_M) || (state_q == SETTLE_M) ||
                         (state_q == CAPT_M)  || (state_q == CALC) || (state_q == HOLD);
  assign RES_VALID     = (state_q == HOLD);
  assign J_PLUS        = jp_q;
  assign J_MINUS       = jm_q;
  assign DELTA_J       = dj_q;
  assign DBG_STATE     = state_q;

endmodule

// File: tb/tb_spgd_meas_sched.sv
// ---------------------------------------------------------------------------
// Bench for spgd_meas_sched. The bench plays the DAC, the ADC front end and
// the result consumer. For every iteration it knows from the sequencing rules
// how long each phase must last (ack delay + 1, settle time, write delay + 1),
// which outputs must be high in each phase, and what J+/J-/dJ must read.
// Ignored inputs are optionally toggled at random to show they have no effect.
// ---------------------------------------------------------------------------
module tb_spgd_meas_sched;
  localparam int W   = 64;
  localparam int S   = 4;
  localparam int TMO = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         dac_ack;
  logic         adc_done;
  logic         adc_write;
  logic [W-1:0] adc_data;
  logic         res_ready;

  logic         busy;
  logic         p_sign;
  logic         p_apply;
  logic         adc_en;
  logic [W-1:0] j_plus;
  logic [W-1:0] j_minus;
  logic [W-1:0] delta_j;
  logic         res_valid;
  logic         err;
  logic [3:0]   dbg_state;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_jp = '0;
  logic [W-1:0] exp_jm = '0;
  logic [W-1:0] exp_dj = '0;
  int           exp_pa_rises = 0;
  int           pa_rises = 0;
  logic         pa_prev = 1'b0;
  logic         noise = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  spgd_meas_sched #(
    .FP_WIDTH(W), .CNT_WIDTH(16), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ADC_CLK(clk), .RST(rst), .START(start), .BUSY(busy),
    .PERTURB_SIGN(p_sign), .PERTURB_APPLY(p_apply), .DAC_ACK(dac_ack),
    .ADC_EN(adc_en), .ADC_DONE(adc_done), .ADC_WRITE(adc_write),
    .ADC_DATA(adc_data), .J_PLUS(j_plus), .J_MINUS(j_minus),
    .DELTA_J(delta_j), .RES_VALID(res_valid), .RES_READY(res_ready),
    .ERR(err), .DBG_STATE(dbg_state)
  );

  // Count rising edges of the DAC request.
  always @(negedge clk) begin
    if (p_apply && !pa_prev) pa_rises++;
    pa_prev = p_apply;
  end

  // ---------------- driver tasks ----------------
  // Drive inputs the DUT must ignore in the current state.
  task automatic set_noise(input bit ack_free, input bit wr_free, input bit start_free);
    adc_done = ($urandom_range(0, 1) == 1);
    if (ack_free) dac_ack = noise && ($urandom_range(0, 1) == 1);
    if (wr_free) begin
      adc_write = noise && ($urandom_range(0, 1) == 1);
      adc_data  = {$urandom(), $urandom()};
    end
    if (start_free) start = noise && ($urandom_range(0, 1) == 1);
  endtask

  task automatic clear_inputs();
    start = 1'b0; dac_ack = 1'b0; adc_write = 1'b0; res_ready = 1'b0;
    adc_data = '0; adc_done = 1'b0;
  endtask

  // One full iteration from IDLE, called at a negedge. abort_m pulses RST
  // in the first CAPT_M cycle instead of finishing.
  task automatic do_iteration(input logic [W-1:0] dp, input logic [W-1:0] dm,
                              input int ack_d, input int wr_d, input int hold_d,
                              input bit early_rdy, input bit abort_m);
    logic [W-1:0] d;
    logic         sg;
    int           n;
    start = 1'b1;
    set_noise(1, 1, 0);
    @(negedge clk);
    for (int ph = 0; ph < 2; ph++) begin
      d  = (ph == 1) ? dm : dp;
      sg = (ph == 1);
      exp_pa_rises++;
      for (int i = 0; i <= ack_d; i++) begin
        tests++;
        if ({busy, p_apply, p_sign, adc_en, res_valid, err} !== {1'b1, 1'b1, sg, 3'b000}) begin
          fails++;
          $display("FAIL apply ph=%0d cyc=%0d: got %b want %b", ph, i,
                   {busy, p_apply, p_sign, adc_en, res_valid, err}, {1'b1, 1'b1, sg, 3'b000});
        end
        set_noise(0, 1, 1);
        dac_ack = (i == ack_d);
        @(negedge clk);
      end
      for (int i = 0; i < S; i++) begin
        tests++;
        if ({busy, p_apply, p_sign, adc_en, res_valid, err} !== {1'b1, 1'b0, sg, 3'b000}) begin
          fails++;
          $display("FAIL settle ph=%0d cyc=%0d: got %b want %b", ph, i,
                   {busy, p_apply, p_sign, adc_en, res_valid, err}, {1'b1, 1'b0, sg, 3'b000});
        end
        set_noise(1, 1, 1);
        @(negedge clk);
      end
      for (int i = 0; i <= wr_d; i++) begin
        tests++;
        if ({busy, p_apply, p_sign, adc_en, res_valid, err} !== {1'b1, 1'b0, sg, 3'b100}) begin
          fails++;
          $display("FAIL capt ph=%0d cyc=%0d: got %b want %b", ph, i,
                   {busy, p_apply, p_sign, adc_en, res_valid, err}, {1'b1, 1'b0, sg, 3'b100});
        end
        if (abort_m && ph == 1) begin
          #2 rst = 1'b1;
          #1;
          exp_jp = '0; exp_jm = '0; exp_dj = '0;
          tests++;
          if ({busy, p_apply, adc_en, res_valid, j_plus, j_minus, delta_j} !== '0) begin
            fails++;
            $display("FAIL async_reset: busy=%b apply=%b en=%b valid=%b jp=%h jm=%h dj=%h want all 0",
                     busy, p_apply, adc_en, res_valid, j_plus, j_minus, delta_j);
          end
          clear_inputs();
          @(negedge clk);
          rst = 1'b0;
          @(negedge clk);
          return;
        end
        set_noise(1, 0, 1);
        adc_write = (i == wr_d);
        if (i == wr_d) adc_data = d;
        @(negedge clk);
      end
      if (ph == 0) exp_jp = dp;
      else         exp_jm = dm;
      tests++;
      if ({adc_en, j_plus, j_minus, delta_j} !== {1'b0, exp_jp, exp_jm, exp_dj}) begin
        fails++;
        $display("FAIL latch ph=%0d: en=%b jp=%h jm=%h dj=%h want en=0 jp=%h jm=%h dj=%h",
                 ph, adc_en, j_plus, j_minus, delta_j, exp_jp, exp_jm, exp_dj);
      end
    end
    // CALC cycle
    tests++;
    if ({busy, p_apply, adc_en, res_valid, err} !== 5'b10000) begin
      fails++;
      $display("FAIL calc: got %b want 10000", {busy, p_apply, adc_en, res_valid, err});
    end
    set_noise(1, 1, 1);
    res_ready = early_rdy;
    exp_q.push_back(dp - dm);
    @(negedge clk);
    n = early_rdy ? 1 : hold_d + 1;
    for (int i = 0; i < n; i++) begin
      tests++;
      if ({busy, p_apply, adc_en, res_valid, err} !== 5'b10010) begin
        fails++;
        $display("FAIL hold cyc=%0d: got %b want 10010", i, {busy, p_apply, adc_en, res_valid, err});
      end
      tests++;
      if ({j_plus, j_minus, delta_j} !== {exp_jp, exp_jm, exp_q[0]}) begin
        fails++;
        $display("FAIL hold_data cyc=%0d: jp=%h jm=%h dj=%h want jp=%h jm=%h dj=%h",
                 i, j_plus, j_minus, delta_j, exp_jp, exp_jm, exp_q[0]);
      end
      set_noise(1, 1, 1);
      res_ready = early_rdy || (i == n - 1);
      @(negedge clk);
    end
    exp_dj = exp_q.pop_front();
    clear_inputs();
    tests++;
    if ({busy, p_apply, p_sign, adc_en, res_valid, err, j_plus, j_minus, delta_j} !==
        {6'b000000, exp_jp, exp_jm, exp_dj}) begin
      fails++;
      $display("FAIL done: flags=%b jp=%h jm=%h dj=%h want flags=000000 jp=%h jm=%h dj=%h",
               {busy, p_apply, p_sign, adc_en, res_valid, err}, j_plus, j_minus, delta_j,
               exp_jp, exp_jm, exp_dj);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, p_apply, p_sign, adc_en, res_valid, err, j_plus, j_minus, delta_j} !== '0) begin
      fails++;
      $display("FAIL reset: flags=%b jp=%h jm=%h dj=%h want all 0",
               {busy, p_apply, p_sign, adc_en, res_valid, err}, j_plus, j_minus, delta_j);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, p_apply, adc_en, res_valid} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_release: got %b want 0000", {busy, p_apply, adc_en, res_valid});
    end
  endtask

  task automatic test_basic();
    noise = 1'b0;
    do_iteration(64'h0005_0000_0000_0000, 64'h0003_0000_0000_0000, 0, 10, 3, 1'b0, 1'b0);
    tests++;
    if (delta_j !== 64'h0002_0000_0000_0000) begin
      fails++;
      $display("FAIL basic_delta: got %h want 0002000000000000", delta_j);
    end
  endtask

  task automatic test_wrap();
    noise = 1'b0;
    do_iteration(64'h0001_0000_0000_0000, 64'h0004_0000_0000_0000, 0, 0, 0, 1'b1, 1'b0);
    tests++;
    if (delta_j !== 64'hFFFD_0000_0000_0000) begin
      fails++;
      $display("FAIL wrap_delta: got %h want fffd000000000000", delta_j);
    end
  endtask

  task automatic test_ignored_inputs();
    logic [W-1:0] a, b;
    // ADC_WRITE in IDLE must not touch the registers.
    for (int i = 0; i < 3; i++) begin
      adc_write = 1'b1;
      adc_data  = {$urandom(), $urandom()};
      @(negedge clk);
    end
    adc_write = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, j_plus, j_minus, delta_j} !== {1'b0, exp_jp, exp_jm, exp_dj}) begin
      fails++;
      $display("FAIL idle_write: busy=%b jp=%h jm=%h dj=%h want busy=0 jp=%h jm=%h dj=%h",
               busy, j_plus, j_minus, delta_j, exp_jp, exp_jm, exp_dj);
    end
    // Random START/ACK/WRITE noise in every state plus a 7-cycle ack delay.
    noise = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      do_iteration(a, b, 7, $urandom_range(0, 5), $urandom_range(0, 4), 1'b0, 1'b0);
    end
    noise = 1'b0;
    tests++;
    if (pa_rises !== exp_pa_rises) begin
      fails++;
      $display("FAIL apply_pulses: got %0d want %0d", pa_rises, exp_pa_rises);
    end
  endtask

  task automatic test_abort();
    noise = 1'b0;
    do_iteration(64'h1234_0000_0000_0001, 64'h0000_0000_0000_0002, 1, 4, 0, 1'b0, 1'b1);
    do_iteration(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0001, 0, 2, 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int k = 0; k < 6; k++) begin
      noise = ($urandom_range(0, 1) == 1);
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      do_iteration(a, b, $urandom_range(0, 12), $urandom_range(0, 12),
                   $urandom_range(0, 5), ($urandom_range(0, 3) == 0), 1'b0);
    end
    noise = 1'b0;
  endtask

`ifdef ADC_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_pa_rises++;
    dac_ack = 1'b1;
    @(negedge clk);
    dac_ack = 1'b0;
    repeat (S) @(negedge clk);
    n = 0;
    while (adc_en === 1'b1 && n < 4 * TMO) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n !== TMO) begin
      fails++;
      $display("FAIL timeout_len: got %0d want %0d", n, TMO);
    end
    tests++;
    if ({busy, err, res_valid, j_plus, j_minus, delta_j} !== {3'b010, exp_jp, exp_jm, exp_dj}) begin
      fails++;
      $display("FAIL timeout_state: busy=%b err=%b valid=%b jp=%h want busy=0 err=1 valid=0 jp=%h",
               busy, err, res_valid, j_plus, exp_jp);
    end
    // The next iteration starts with ERR cleared (checked in its first cycle).
    do_iteration(64'h0000_0000_0000_0007, 64'h0000_0000_0000_0009, 0, 1, 0, 1'b0, 1'b0);
  endtask
`endif

  // Bounded run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_ignored_inputs();
    test_abort();
    test_random();
`ifdef ADC_TIMEOUT_EN
    test_timeout();
`endif
    tests++;
    if (pa_rises !== exp_pa_rises) begin
      fails++;
      $display("FAIL apply_pulses_total: got %0d want %0d", pa_rises, exp_pa_rises);
    end
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
